// File: rtl/conv_pkg.sv
// Shared constants, bank select codes and FSM state type for the CONV memory responder.
// Every bank depth is a power of two, so range checks reduce to "no high address bits set".
package conv_pkg;

  localparam int DW        = 20;
  localparam int AW        = 12;
  localparam int IMG_DEPTH = 4096;
  localparam int L0_DEPTH  = 4096;
  localparam int L1_DEPTH  = 1024;
  localparam int L2_DEPTH  = 2048;
  localparam int CNT_W     = 13;
  localparam int NBANK     = 5;

  localparam logic [2:0] CSEL_L0K0 = 3'b001;
  localparam logic [2:0] CSEL_L0K1 = 3'b010;
  localparam logic [2:0] CSEL_L1K0 = 3'b011;
  localparam logic [2:0] CSEL_L1K1 = 3'b100;
  localparam logic [2:0] CSEL_L2   = 3'b101;

  typedef enum logic [1:0] {S_LOAD, S_READY, S_RUN, S_DONE} state_t;

  function automatic logic csel_ok(input logic [2:0] sel);
    return (sel >= CSEL_L0K0) && (sel <= CSEL_L2);
  endfunction

  function automatic int bank_depth(input logic [2:0] sel);
    int depth;
    depth = 0;
    case (sel)
      CSEL_L0K0, CSEL_L0K1: depth = L0_DEPTH;
      CSEL_L1K0, CSEL_L1K1: depth = L1_DEPTH;
      CSEL_L2:              depth = L2_DEPTH;
      default:              depth = 0;
    endcase
    return depth;
  endfunction

  // Address bits that must be zero for an access to land inside a bank of this depth.
  function automatic logic [AW-1:0] hi_mask(input int depth);
    return AW'((2 ** AW) - depth);
  endfunction

  function automatic logic addr_ok(input logic [AW-1:0] addr, input logic [AW-1:0] mask);
    return (addr & mask) == '0;
  endfunction

endpackage

// File: rtl/conv_mem_responder_if.sv
// Bus between the CONV engine/host and the memory responder.
// Handshake: ready=1 means the image is loaded; the engine raises busy, ready drops on the
// first edge that samples busy=1, and the falling edge of busy marks completion (done).
interface conv_mem_responder_if;
  import conv_pkg::*;

  logic          img_we;
  logic [AW-1:0] img_waddr;
  logic [DW-1:0] img_wdata;
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic [2:0]    csel;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          done;
  logic          err;

  modport slave (
    input  img_we, img_waddr, img_wdata, busy, iaddr, csel, crd, caddr_rd, cwr, caddr_wr, cdata_wr,
    output ready, idata, cdata_rd, done, err
  );

  modport master (
    output img_we, img_waddr, img_wdata, busy, iaddr, csel, crd, caddr_rd, cwr, caddr_wr, cdata_wr,
    input  ready, idata, cdata_rd, done, err
  );

endinterface

// File: rtl/conv_sp_ram.sv
// One write port, one registered read port; a same-address read and write return the old word.
module conv_sp_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 20,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/conv_mem_responder.sv
// Memory/host-side responder for the CONV engine: image store, five layer banks,
// and the load/ready/run/done handshake FSM.
module conv_mem_responder
  import conv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  conv_mem_responder_if.slave  bus,
  output state_t               dbg_state,
  output logic [CNT_W-1:0]     dbg_load_cnt
);

  localparam logic [AW-1:0] IMG_HI = hi_mask(IMG_DEPTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             img_src_q, img_src_d;
  logic [2:0]       rd_src_q, rd_src_d;

  logic             img_we_ok, img_re, waddr_ok, iaddr_ok, rd_ok, wr_ok;
  logic [DW-1:0]    img_rdata;
  logic [DW-1:0]    bank_rdata [NBANK];
  logic [DW-1:0]    cdata_mux;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    img_src_d = img_src_q;
    rd_src_d  = rd_src_q;
    img_we_ok = 1'b0;
    img_re    = 1'b0;
    waddr_ok  = addr_ok(bus.img_waddr, IMG_HI);
    iaddr_ok  = addr_ok(bus.iaddr, IMG_HI);
    rd_ok     = csel_ok(bus.csel) && addr_ok(bus.caddr_rd, hi_mask(bank_depth(bus.csel)));
    wr_ok     = csel_ok(bus.csel) && addr_ok(bus.caddr_wr, hi_mask(bank_depth(bus.csel)));

    if (bus.img_we) begin
      if ((state_q != S_LOAD) || !waddr_ok) begin
        err_d = 1'b1;
      end else begin
        img_we_ok = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(IMG_DEPTH)) state_d = S_READY;
      end
    end

    case (state_q)
      S_READY: if (bus.busy)  state_d = S_RUN;
      S_RUN:   if (!bus.busy) state_d = S_DONE;
      default: ;
    endcase

    // The image port streams every cycle while the engine may use it and freezes otherwise.
    if ((state_q == S_READY) || (state_q == S_RUN)) begin
      img_re    = iaddr_ok;
      img_src_d = iaddr_ok;
      if (!iaddr_ok) err_d = 1'b1;
    end

    if (bus.crd) begin
      rd_src_d = rd_ok ? bus.csel : 3'b000;
      if (!rd_ok) err_d = 1'b1;
    end
    if (bus.cwr && !wr_ok) err_d = 1'b1;

    ready_d = (state_d == S_READY);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_LOAD;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      img_src_q <= 1'b0;
      rd_src_q  <= 3'b000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      img_src_q <= img_src_d;
      rd_src_q  <= rd_src_d;
    end
  end

  conv_sp_ram #(.DEPTH(IMG_DEPTH), .WIDTH(DW)) u_img (
    .clk   (clk),
    .we    (img_we_ok),
    .waddr (bus.img_waddr),
    .wdata (bus.img_wdata),
    .re    (img_re),
    .raddr (bus.iaddr),
    .rdata (img_rdata)
  );

  // Bank b answers csel code b+1; its index is the low address bits once the range check passed.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    localparam logic [2:0] CODE  = 3'(b + 1);
    localparam int         DEPTH = bank_depth(CODE);
    localparam int         BAW   = $clog2(DEPTH);

    conv_sp_ram #(.DEPTH(DEPTH), .WIDTH(DW)) u_ram (
      .clk   (clk),
      .we    (bus.cwr && wr_ok && (bus.csel == CODE)),
      .waddr (bus.caddr_wr[BAW-1:0]),
      .wdata (bus.cdata_wr),
      .re    (bus.crd && rd_ok && (bus.csel == CODE)),
      .raddr (bus.caddr_rd[BAW-1:0]),
      .rdata (bank_rdata[b])
    );
  end

  always_comb begin
    cdata_mux = '0;
    if (csel_ok(rd_src_q)) cdata_mux = bank_rdata[rd_src_q - 3'd1];
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.idata    = img_src_q ? img_rdata : '0;
  assign bus.cdata_rd = cdata_mux;
  assign dbg_state    = state_q;
  assign dbg_load_cnt = cnt_q;

endmodule

// File: tb/tb_conv_mem_responder.sv
// Self-checking bench for conv_mem_responder: image load handshake, layer banks, error flags, resets.
module tb_conv_mem_responder;
  import conv_pkg::*;

  logic             clk;
  logic             reset;
  state_t           dbg_state;
  logic [CNT_W-1:0] dbg_load_cnt;

  conv_mem_responder_if bus ();

  conv_mem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .dbg_state    (dbg_state),
    .dbg_load_cnt (dbg_load_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] img_exp_q[$];
  logic          img_chk = 1'b0;
  logic [DW-1:0] mdl [8][4096];
  bit            wrt [8][4096];
  logic [DW-1:0] last_rd_exp = '0;
  logic [DW-1:0] last_img = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int depth_of(input logic [2:0] sel);
    case (sel)
      3'd1, 3'd2: return 4096;
      3'd3, 3'd4: return 1024;
      3'd5:       return 2048;
      default:    return 0;
    endcase
  endfunction

  // Output monitor: compares read data one edge after the strobe that requested it.
  initial begin
    forever begin
      logic took_rd, took_img;
      @(posedge clk);
      took_rd  = bus.crd;
      took_img = img_chk;
      #1;
      if (took_rd) begin
        if (exp_q.size() == 0) chk("cdata_rd_underflow", 32'd1, 32'd0);
        else chk("cdata_rd", bus.cdata_rd, exp_q.pop_front());
      end
      if (took_img) begin
        if (img_exp_q.size() == 0) chk("idata_underflow", 32'd1, 32'd0);
        else chk("idata", bus.idata, img_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image();
    for (int i = 0; i < IMG_DEPTH; i++) begin
      bus.img_we    = 1'b1;
      bus.img_waddr = AW'(i);
      bus.img_wdata = DW'(i);
      if (i == IMG_DEPTH - 1) begin
        chk("ready_before_last", bus.ready, 0);
        chk("cnt_before_last", dbg_load_cnt, 32'd4095);
      end
      step();
    end
    bus.img_we = 1'b0;
  endtask

  task automatic layer_op(input logic [2:0] sel, input bit rd, input logic [AW-1:0] ra,
                          input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int dep;
    logic [DW-1:0] e;
    dep          = depth_of(sel);
    bus.csel     = sel;
    bus.crd      = rd;
    bus.caddr_rd = ra;
    bus.cwr      = wr;
    bus.caddr_wr = wa;
    bus.cdata_wr = wd;
    if (rd) begin
      e = (int'(ra) < dep) ? mdl[sel][ra] : '0;
      exp_q.push_back(e);
      last_rd_exp = e;
    end
    if (wr && (int'(wa) < dep)) begin
      mdl[sel][wa] = wd;
      wrt[sel][wa] = 1'b1;
    end
    step();
    bus.crd = 1'b0;
    bus.cwr = 1'b0;
  endtask

  task automatic img_rd(input logic [AW-1:0] a);
    bus.iaddr = a;
    img_chk   = 1'b1;
    img_exp_q.push_back(DW'(a));
    last_img  = DW'(a);
    step();
    img_chk   = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr(input int dep);
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 15));
    return AW'(dep - 1 - int'($urandom_range(0, 15)));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]    sel;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    bit            do_rd;

    reset = 1'b1;
    bus.img_we = 1'b0; bus.img_waddr = '0; bus.img_wdata = '0;
    bus.busy = 1'b0;   bus.iaddr = '0;
    bus.csel = '0;     bus.crd = 1'b0; bus.caddr_rd = '0;
    bus.cwr = 1'b0;    bus.caddr_wr = '0; bus.cdata_wr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_idata", bus.idata, 0);
    chk("rst_cdata_rd", bus.cdata_rd, 0);
    chk("rst_state", dbg_state, S_LOAD);
    chk("rst_cnt", dbg_load_cnt, 0);
    reset = 1'b0;
    step();

    // Image load and READY
    load_image();
    chk("ready_after_load", bus.ready, 1);
    chk("state_ready", dbg_state, S_READY);
    chk("cnt_full", dbg_load_cnt, 32'd4096);
    chk("err_after_load", bus.err, 0);

    // Layer banks: directed cases
    layer_op(CSEL_L0K0, 0, '0, 1, 12'd5, 20'h12345);
    layer_op(CSEL_L0K1, 0, '0, 1, 12'd5, 20'h0ABCD);
    layer_op(CSEL_L0K0, 1, 12'd5, 0, '0, '0);
    layer_op(CSEL_L0K1, 1, 12'd5, 0, '0, '0);
    layer_op(CSEL_L1K0, 0, '0, 1, 12'd7, 20'h00AAA);
    layer_op(CSEL_L1K0, 1, 12'd7, 1, 12'd7, 20'h00BBB);
    layer_op(CSEL_L1K0, 1, 12'd7, 0, '0, '0);
    layer_op(CSEL_L2,   0, '0, 1, 12'd2047, 20'hFFFFF);
    layer_op(CSEL_L2,   1, 12'd2047, 0, '0, '0);
    layer_op(CSEL_L1K1, 0, '0, 1, 12'd1023, 20'h80001);
    layer_op(CSEL_L1K1, 1, 12'd1023, 0, '0, '0);

    // Layer banks: random traffic against the model, reads only of written words
    for (int it = 0; it < 120; it++) begin
      sel   = 3'($urandom_range(1, 5));
      wa    = pick_addr(depth_of(sel));
      ra    = ($urandom_range(0, 3) == 0) ? wa : pick_addr(depth_of(sel));
      wd    = DW'($urandom);
      do_rd = wrt[sel][ra];
      layer_op(sel, do_rd, ra, 1, wa, wd);
    end
    step();
    step();
    chk("cdata_hold", bus.cdata_rd, last_rd_exp);
    chk("err_after_valid_ops", bus.err, 0);

    // Start: ready overlaps busy for one cycle
    bus.busy = 1'b1;
    chk("ready_overlap", bus.ready, 1);
    step();
    chk("ready_drop", bus.ready, 0);
    chk("state_run", dbg_state, S_RUN);

    // Image reads in RUN
    img_rd(12'h041);
    for (int i = 0; i < 10; i++) img_rd(AW'($urandom_range(0, IMG_DEPTH - 1)));
    img_rd(12'h000);
    img_rd(12'hFFF);

    // Finish: done is sticky and the image port freezes
    bus.busy = 1'b0;
    chk("done_before_fall", bus.done, 0);
    step();
    chk("done_rise", bus.done, 1);
    chk("state_done", dbg_state, S_DONE);
    bus.iaddr = 12'h999;
    repeat (3) step();
    chk("done_hold", bus.done, 1);
    chk("idata_hold_done", bus.idata, last_img);
    chk("err_before_late_we", bus.err, 0);
    bus.img_we = 1'b1;
    bus.img_waddr = 12'h010;
    step();
    bus.img_we = 1'b0;
    chk("err_we_in_done", bus.err, 1);

    // Asynchronous reset from DONE, then layer-port errors in LOAD
    reset = 1'b1;
    #1;
    chk("arst_done", bus.done, 0);
    chk("arst_err", bus.err, 0);
    chk("arst_state", dbg_state, S_LOAD);
    step();
    reset = 1'b0;
    bus.iaddr = 12'h123;
    step();
    step();
    chk("idata_hold_load", bus.idata, 0);
    layer_op(CSEL_L1K0, 0, '0, 1, 12'd0, 20'h00C0C);
    chk("err_before_bad_wr", bus.err, 0);
    layer_op(CSEL_L1K0, 0, '0, 1, 12'd1024, 20'h33333);
    chk("err_bad_wr_addr", bus.err, 1);
    layer_op(CSEL_L1K0, 1, 12'd0, 0, '0, '0);
    layer_op(3'b110, 1, 12'd5, 0, '0, '0);
    layer_op(CSEL_L2, 1, 12'd2048, 0, '0, '0);
    layer_op(3'b000, 1, 12'd0, 0, '0, '0);
    step();
    chk("err_sticky", bus.err, 1);

    // Reset in the middle of RUN
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    load_image();
    bus.busy = 1'b1;
    step();
    chk("state_run2", dbg_state, S_RUN);
    layer_op(3'b111, 1, 12'd0, 0, '0, '0);
    step();
    chk("err_in_run", bus.err, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", bus.ready, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_state", dbg_state, S_LOAD);
    chk("mid_rst_cnt", dbg_load_cnt, 0);
    step();
    reset = 1'b0;
    bus.busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.img_we    = 1'b1;
      bus.img_waddr = AW'(i);
      bus.img_wdata = DW'(i);
      step();
    end
    bus.img_we = 1'b0;
    chk("reload_cnt", dbg_load_cnt, 3);
    chk("reload_state", dbg_state, S_LOAD);
    chk("reload_ready", bus.ready, 0);

    step();
    chk("queues_drained", exp_q.size() + img_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
